mult_sequencer: RTL

//  Sequences the shift-add 2's-complement multiplier datapath: the 9-bit add/sub unit, X/A/B registers and shift chain.

---
 rtl/mult_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer: counted, handshaked control sequencer for the shift-add
// two's-complement multiplier (adder, X/A/B registers and shift chain).
// Run starts one multiply, which then holds done until run is released.
module mult_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     run,
  input  logic                     clear_load,
  input  logic                     M,
  output logic                     ClrA,
  output logic                     LdB,
  output logic                     LoadA,
  output logic                     fn,
  output logic                     Shift_En,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             blank;
  logic             is_last;

  logic clr_a_d;
  logic ld_b_d;
  logic load_a_d;
  logic fn_d;
  logic shift_d;
  logic busy_d;
  logic done_d;

  assign is_last = (cnt_q == LAST_BIT);

  // State and bit counter registers; reset forces IDLE with the counter at 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Output blanking: high during reset and until the first edge after release.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blank <= 1'b1;
    end else begin
      blank <= 1'b0;
    end
  end

  // Next-state, counter update and Moore strobe decode (LoadA also uses M).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    clr_a_d   = 1'b0;
    ld_b_d    = 1'b0;
    load_a_d  = 1'b0;
    fn_d      = 1'b0;
    shift_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        // clear_load wins over run so a load never races a multiply start
        ld_b_d  = clear_load;
        clr_a_d = clear_load;
        if (run && !clear_load) begin
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        clr_a_d   = 1'b1;
        busy_d    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        busy_d    = 1'b1;
        load_a_d  = M;
        // the sign bit of the multiplier carries negative weight
        fn_d      = is_last;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy_d  = 1'b1;
        shift_d = 1'b1;
        if (is_last) begin
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt   = cnt_q + CNT_W'(1);
          state_nxt = ST_ADD;
        end
      end
      ST_HOLD: begin
        done_d = 1'b1;
        if (clear_load) begin
          ld_b_d    = 1'b1;
          clr_a_d   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!run) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ClrA     = clr_a_d  & ~blank;
  assign LdB      = ld_b_d   & ~blank;
  assign LoadA    = load_a_d & ~blank;
  assign fn       = fn_d     & ~blank;
  assign Shift_En = shift_d  & ~blank;
  assign busy     = busy_d   & ~blank;
  assign done     = done_d   & ~blank;
  assign bit_cnt  = cnt_q;

endmodule
